// File: rtl/seg_scan_driver.sv
// ============================================================================
//  Module   : seg_scan_driver
//  Purpose  : 3-digit time-multiplexed seven-segment scanner with a per-frame
//             shadow register. Optional macro LEADING_ZERO_BLANK_EN blanks
//             leading zeros on the hundreds and tens digits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank,
    output logic [2:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int                 c_DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);
    localparam logic [2:0]         c_AN_POL   = {3{ACTIVE_LOW}};
    localparam logic [6:0]         c_SEG_POL  = {7{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        S_ONES     = 2'd0,
        S_TENS     = 2'd1,
        S_HUNDREDS = 2'd2
    } state_t;

    logic [c_DIV_W-1:0] r_div_cnt;
    state_t             r_idx;
    logic [11:0]        r_shadow;
    logic               r_frame_tick;
    logic [2:0]         r_an;
    logic [6:0]         r_seg;

    logic               w_div_last;
    logic               w_frame_end;
    logic [3:0]         w_nibble;
    logic [2:0]         w_an_sel;
    logic               w_lz_hide;
    logic               w_digit_on;
    logic [2:0]         w_an_hi;
    logic [6:0]         w_seg_hi;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] v;
        case (nib)
            4'd0:    v = 7'h3F;
            4'd1:    v = 7'h06;
            4'd2:    v = 7'h5B;
            4'd3:    v = 7'h4F;
            4'd4:    v = 7'h66;
            4'd5:    v = 7'h6D;
            4'd6:    v = 7'h7D;
            4'd7:    v = 7'h07;
            4'd8:    v = 7'h7F;
            4'd9:    v = 7'h6F;
            default: v = 7'h40;
        endcase
        return v;
    endfunction

    assign w_div_last  = (r_div_cnt == c_DIV_LAST);
    assign w_frame_end = w_div_last && (r_idx == S_HUNDREDS);

    // Scan sequencing; inputs are sampled only on the frame boundary edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_idx        <= S_ONES;
            r_shadow     <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
            if (w_div_last) begin
                r_div_cnt <= '0;
                case (r_idx)
                    S_ONES:  r_idx <= S_TENS;
                    S_TENS:  r_idx <= S_HUNDREDS;
                    default: r_idx <= S_ONES;
                endcase
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end
            if (w_frame_end) begin
                r_shadow <= {hundreds, tens, ones};
            end
        end
    end

    always_comb begin
        w_nibble = r_shadow[3:0];
        w_an_sel = 3'b000;
        case (r_idx)
            S_ONES: begin
                w_nibble = r_shadow[3:0];
                w_an_sel = 3'b001;
            end
            S_TENS: begin
                w_nibble = r_shadow[7:4];
                w_an_sel = 3'b010;
            end
            S_HUNDREDS: begin
                w_nibble = r_shadow[11:8];
                w_an_sel = 3'b100;
            end
            default: begin
                w_nibble = r_shadow[3:0];
                w_an_sel = 3'b000;
            end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    assign w_lz_hide = ((r_idx == S_HUNDREDS) && (r_shadow[11:8] == 4'd0)) ||
                       ((r_idx == S_TENS)     && (r_shadow[11:4] == 8'd0));
`else
    assign w_lz_hide = 1'b0;
`endif

    assign w_digit_on = !blank && !w_lz_hide;
    assign w_an_hi    = w_digit_on ? w_an_sel : 3'b000;
    assign w_seg_hi   = w_digit_on ? f_decode(w_nibble) : 7'h00;

    // Reset forces the display dark without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= c_AN_POL;
            r_seg <= c_SEG_POL;
        end else begin
            r_an  <= w_an_hi ^ c_AN_POL;
            r_seg <= w_seg_hi ^ c_SEG_POL;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
// ============================================================================
//  Module   : tb_seg_scan_driver
//  Purpose  : Self-checking bench for seg_scan_driver; two instances
//             (REFRESH_DIV=4 active-low, REFRESH_DIV=1 active-high).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_driver;

    logic       clk;
    logic       rst;
    logic [3:0] hundreds, tens, ones;
    logic       blank;
    logic [2:0] an0, an1;
    logic [6:0] seg0, seg1;
    logic       ft0, ft1;

    int n_checks = 0;
    int n_pass   = 0;

    int          m_n  [2];
    logic [11:0] m_sh [2];

    seg_scan_driver #(.REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .hundreds(hundreds), .tens(tens), .ones(ones),
        .blank(blank), .an(an0), .seg(seg0), .frame_tick(ft0)
    );

    seg_scan_driver #(.REFRESH_DIV(1), .ACTIVE_LOW(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .hundreds(hundreds), .tens(tens), .ones(ones),
        .blank(blank), .an(an1), .seg(seg1), .frame_tick(ft1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [6:0] lut(input logic [3:0] nib);
        logic [6:0] t [10];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (nib > 4'd9) return 7'h40;
        return t[nib];
    endfunction

    // Outputs after edge n (0-based, since reset release) from the state before that edge.
    task automatic model(input int div, input bit al, input int n, input logic [11:0] sh,
                         input logic bl, output logic [2:0] ea, output logic [6:0] es,
                         output logic ef);
        int         idx;
        logic [3:0] nib;
        logic       hide;
        idx  = (n / div) % 3;
        nib  = sh[idx*4 +: 4];
        hide = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        hide = (idx == 2 && sh[11:8] == 4'd0) || (idx == 1 && sh[11:4] == 8'd0);
`endif
        if (bl || hide) begin
            ea = 3'b000;
            es = 7'h00;
        end else begin
            ea = 3'(1 << idx);
            es = lut(nib);
        end
        if (al) begin
            ea = ~ea;
            es = ~es;
        end
        ef = ((n % (3 * div)) == (3 * div - 1));
    endtask

    // Model update and per-cycle compare against both instances.
    always @(posedge clk) begin
        logic [2:0] ea [2];
        logic [6:0] es [2];
        logic       ef [2];
        int         div;
        bit         al;
        for (int i = 0; i < 2; i++) begin
            div = (i == 0) ? 4 : 1;
            al  = (i == 0);
            if (rst) begin
                m_n[i]  = 0;
                m_sh[i] = 12'h000;
                ea[i]   = al ? 3'b111 : 3'b000;
                es[i]   = al ? 7'h7F : 7'h00;
                ef[i]   = 1'b0;
            end else begin
                model(div, al, m_n[i], m_sh[i], blank, ea[i], es[i], ef[i]);
                if (ef[i]) m_sh[i] = {hundreds, tens, ones};
                m_n[i]++;
            end
        end
        #1;
        chk("an0", {29'd0, an0}, {29'd0, ea[0]});
        chk("seg0", {25'd0, seg0}, {25'd0, es[0]});
        chk("tick0", {31'd0, ft0}, {31'd0, ef[0]});
        chk("an1", {29'd0, an1}, {29'd0, ea[1]});
        chk("seg1", {25'd0, seg1}, {25'd0, es[1]});
        chk("tick1", {31'd0, ft1}, {31'd0, ef[1]});
    end

    task automatic wait_after(input int e);
        int guard;
        guard = 0;
        while (m_n[0] < e && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (m_n[0] < e) chk("wait_bound", 32'(m_n[0]), 32'(e));
    endtask

    task automatic randomize_inputs();
        hundreds = 4'($urandom_range(0, 15));
        tens     = 4'($urandom_range(0, 15));
        ones     = 4'($urandom_range(0, 15));
        blank    = ($urandom_range(0, 7) == 0);
    endtask

    initial begin
        int k;
        rst = 1'b1; blank = 1'b0;
        hundreds = 4'd1; tens = 4'd2; ones = 4'd3;
        repeat (3) @(negedge clk);
        chk("rst_an", {29'd0, an0}, 32'b111);
        chk("rst_seg", {25'd0, seg0}, 32'b1111111);

        rst = 1'b0;
        @(negedge clk);
        chk("first_an", {29'd0, an0}, 32'b110);
        chk("first_seg", {25'd0, seg0}, 32'b1000000);
        k = 1;
        while (!ft0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("first_tick_cycle", 32'(k), 32'd12);

        wait_after(13);
        chk("ones_an", {29'd0, an0}, 32'b110);
        chk("ones_seg", {25'd0, seg0}, 32'b0110000);
        wait_after(17);
        chk("tens_an", {29'd0, an0}, 32'b101);
        chk("tens_seg", {25'd0, seg0}, 32'b0100100);
        wait_after(21);
        chk("hund_an", {29'd0, an0}, 32'b011);
        chk("hund_seg", {25'd0, seg0}, 32'b1111001);

        wait_after(26);
        hundreds = 4'd4; tens = 4'd5; ones = 4'd6;
        wait_after(29);
        chk("no_tear_seg", {25'd0, seg0}, 32'b0100100);
        wait_after(37);
        chk("new_ones_seg", {25'd0, seg0}, 32'b0000010);

        wait_after(40);
        tens = 4'hA;
        wait_after(53);
        chk("dash_an", {29'd0, an0}, 32'b101);
        chk("dash_seg", {25'd0, seg0}, 32'b0111111);

        wait_after(60);
        blank = 1'b1;
        wait_after(61);
        chk("blank_an", {29'd0, an0}, 32'b111);
        chk("blank_seg", {25'd0, seg0}, 32'b1111111);
        wait_after(80);
        blank = 1'b0;
        hundreds = 4'd0; tens = 4'd0; ones = 4'd7;

        wait_after(85);
        chk("lz_ones_an", {29'd0, an0}, 32'b110);
        chk("lz_ones_seg", {25'd0, seg0}, 32'b1111000);
        wait_after(89);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_tens_an", {29'd0, an0}, 32'b111);
        chk("lz_tens_seg", {25'd0, seg0}, 32'b1111111);
`else
        chk("lz_tens_an", {29'd0, an0}, 32'b101);
        chk("lz_tens_seg", {25'd0, seg0}, 32'b1000000);
`endif
        wait_after(93);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_hund_an", {29'd0, an0}, 32'b111);
`else
        chk("lz_hund_an", {29'd0, an0}, 32'b011);
`endif

        repeat (300) begin
            @(negedge clk);
            randomize_inputs();
        end

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_an0", {29'd0, an0}, 32'b111);
        chk("async_seg0", {25'd0, seg0}, 32'b1111111);
        chk("async_tick0", {31'd0, ft0}, 32'd0);
        chk("async_an1", {29'd0, an1}, 32'b000);
        chk("async_seg1", {25'd0, seg1}, 32'b0000000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (200) begin
            @(negedge clk);
            randomize_inputs();
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
